// File: rtl/tqvp_vga_capture.sv
// VGA-stream frame grabber for TinyQV: samples a 1-bit pixel stream into a COLSxROWS bitmap.
// Optional hsync-period / lines-per-frame measurement registers under VGA_CAP_MEASURE_EN.
module tqvp_vga_capture #(
    parameter int PIXEL_COUNT     = 320,
    parameter int COLS            = 20,
    parameter int ROWS            = 16,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    localparam int   COL_W   = $clog2(COLS);
    localparam int   ROW_W   = $clog2(ROWS);
    localparam int   IDX_W   = $clog2(PIXEL_COUNT);
    localparam int   WORDS   = PIXEL_COUNT / 32;
    localparam logic ACT_LVL = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_VS   = 2'd1,
        S_WAIT_LINE = 2'd2,
        S_CAPTURE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [9:0] hstart;
        logic [6:0] xdiv;
        logic [9:0] vstart;
        logic [6:0] ydiv;
    } cfg_t;

    cfg_t             cfg_q;
    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d, scol;
    logic [9:0]       skip_q, skip_d;
    logic [9:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             irq_q;
    logic             sample;
    logic [IDX_W-1:0] px_idx;
    logic [PIXEL_COUNT-1:0] vram;

    logic wr_en, ctrl_wr, arm;
    logic hs_act, vs_act, hs_prev, vs_prev, hs_edge, vs_edge;
    logic pixel;
    logic [9:0]  meas_h, meas_v;
    logic [31:0] rd_data;
    logic        unused_ok;

    assign uo_out     = 8'd0;
    assign data_ready = 1'b1;
    assign user_interrupt = irq_q;
    assign unused_ok  = &{1'b0, ui_in[7:3], data_in[31:10]};

    assign wr_en   = (data_write_n != 2'b11);
    assign ctrl_wr = wr_en && (address == 6'h30);
    assign arm     = ctrl_wr && data_in[0];

    // ---------------- sync trailing-edge detection ----------------
    assign hs_act  = (ui_in[0] == ACT_LVL);
    assign vs_act  = (ui_in[1] == ACT_LVL);
    assign pixel   = ui_in[2];
    assign hs_edge = hs_prev & ~hs_act;
    assign vs_edge = vs_prev & ~vs_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_prev <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            hs_prev <= hs_act;
            vs_prev <= vs_act;
        end
    end

    // ---------------- config registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q.hstart <= 10'd0;
            cfg_q.xdiv   <= 7'd56;
            cfg_q.vstart <= 10'd0;
            cfg_q.ydiv   <= 7'd47;
        end else if (wr_en) begin
            case (address)
                6'h31: cfg_q.hstart <= data_in[9:0];
                6'h32: cfg_q.xdiv   <= data_in[6:0];
                6'h33: cfg_q.vstart <= data_in[9:0];
                6'h34: cfg_q.ydiv   <= data_in[6:0];
                default: ;
            endcase
        end
    end

    // ---------------- capture FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            skip_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        skip_d  = skip_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        sample  = 1'b0;
        scol    = col_q;
        case (state_q)
            S_IDLE: ;
            S_WAIT_VS: begin
                if (vs_edge) begin
                    row_d   = '0;
                    skip_d  = cfg_q.vstart;
                    state_d = S_WAIT_LINE;
                end
            end
            S_WAIT_LINE: begin
                if (vs_edge) begin
                    state_d = S_IDLE;
                end else if (hs_edge) begin
                    if (skip_q == 10'd0) begin
                        col_d   = '0;
                        state_d = S_CAPTURE;
                        // A zero start offset samples in the edge cycle itself
                        if (cfg_q.hstart == 10'd0) begin
                            sample = 1'b1;
                            scol   = '0;
                        end else begin
                            cnt_d = cfg_q.hstart - 10'd1;
                        end
                    end else begin
                        skip_d = skip_q - 10'd1;
                    end
                end
            end
            S_CAPTURE: begin
                if (vs_edge) begin
                    state_d = S_IDLE;
                end else if (hs_edge) begin
                    // Line ended early: leave the row partial and treat this edge as consumed
                    row_d   = row_q + ROW_W'(1);
                    skip_d  = 10'(cfg_q.ydiv);
                    state_d = S_WAIT_LINE;
                end else if (cnt_q == 10'd0) begin
                    sample = 1'b1;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (sample) begin
            cnt_d = 10'(cfg_q.xdiv);
            col_d = scol + COL_W'(1);
            if (scol == COL_W'(COLS - 1)) begin
                if (row_q == ROW_W'(ROWS - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    row_d   = row_q + ROW_W'(1);
                    skip_d  = 10'(cfg_q.ydiv);
                    state_d = S_WAIT_LINE;
                end
            end
        end

        // Any CTRL access acknowledges; it outranks a completing frame
        if (ctrl_wr) done_d = 1'b0;
        if (arm)     state_d = S_WAIT_VS;
    end

    assign px_idx = IDX_W'(row_q) * IDX_W'(COLS) + IDX_W'(scol);

    always_ff @(posedge clk) begin
        if (sample) vram[px_idx] <= pixel;
    end

    always_ff @(posedge clk) begin
        if (rst)          irq_q <= 1'b0;
        else if (ctrl_wr) irq_q <= 1'b0;
        else if (done_q)  irq_q <= 1'b1;
    end

    // ---------------- measurement ----------------
`ifdef VGA_CAP_MEASURE_EN
    logic [9:0] hcnt_q, line_q, hperiod_q, vlines_q;

    // hcnt lags the true clock count by one, hence the +1 when latching
    always_ff @(posedge clk) begin
        if (rst) begin
            hcnt_q    <= '0;
            line_q    <= '0;
            hperiod_q <= '0;
            vlines_q  <= '0;
        end else begin
            if (hs_edge) begin
                hcnt_q    <= '0;
                hperiod_q <= (hcnt_q == 10'h3FF) ? 10'h3FF : hcnt_q + 10'd1;
            end else if (hcnt_q != 10'h3FF) begin
                hcnt_q <= hcnt_q + 10'd1;
            end
            if (vs_edge) begin
                line_q   <= '0;
                vlines_q <= line_q;
            end else if (hs_edge && line_q != 10'h3FF) begin
                line_q <= line_q + 10'd1;
            end
        end
    end

    assign meas_h = hperiod_q;
    assign meas_v = vlines_q;
`else
    assign meas_h = 10'd0;
    assign meas_v = 10'd0;
`endif

    // ---------------- read path ----------------
    always_comb begin
        rd_data = 32'd0;
        if (address[5:2] < 4'(WORDS)) begin
            rd_data = vram[{address[5:2], 5'b0} +: 32];
        end else begin
            case (address)
                6'h31: rd_data = {22'd0, cfg_q.hstart};
                6'h32: rd_data = {25'd0, cfg_q.xdiv};
                6'h33: rd_data = {22'd0, cfg_q.vstart};
                6'h34: rd_data = {25'd0, cfg_q.ydiv};
                6'h38: rd_data = {29'd0, state_q, done_q};
                6'h3C: rd_data = {22'd0, meas_h};
                6'h3D: rd_data = {22'd0, meas_v};
                default: rd_data = 32'd0;
            endcase
        end
    end

    assign data_out = (data_read_n != 2'b11) ? rd_data : 32'd0;

endmodule

// File: tb/tb_tqvp_vga_capture.sv
// Directed bench for tqvp_vga_capture: reset, config, full frame, irq clear, abort, re-arm, measurement.
module tb_tqvp_vga_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hs = 1'b1, vs = 1'b1, pix = 1'b0;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address = 6'h00;
    logic [31:0] data_in = 32'd0;
    logic [1:0]  data_write_n = 2'b11;
    logic [1:0]  data_read_n = 2'b11;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    int checks = 0;
    int errors = 0;
    logic [31:0] snap_before, snap_after;

    assign ui_in = {5'b0, pix, vs, hs};

    always #5 clk = ~clk;

    tqvp_vga_capture dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out),
        .address(address), .data_in(data_in), .data_write_n(data_write_n),
        .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
        .user_interrupt(user_interrupt)
    );

    task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        address = a; data_in = d; data_write_n = 2'b10;
        @(posedge clk); #1;
        data_write_n = 2'b11;
    endtask

    task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
        address = a; data_read_n = 2'b10;
        #1 d = data_out;
        data_read_n = 2'b11;
    endtask

    // One video line of lp clocks: hsync active for the first 8 clocks.
    // pix_c >= 0 drives pixel high over clocks pix_c-1..pix_c+1; wr_c >= 0 arms at that clock.
    task automatic vline(input int lp, input bit vs_low, input int pix_c, input int wr_c);
        for (int c = 0; c < lp; c++) begin
            @(posedge clk); #1;
            if (wr_c >= 0 && c == wr_c + 1) begin
                data_write_n = 2'b11;
                address = 6'h38; data_read_n = 2'b10;
                #1 snap_after = data_out;
                data_read_n = 2'b11;
            end
            hs  = (c < 8) ? 1'b0 : 1'b1;
            vs  = vs_low ? 1'b0 : 1'b1;
            pix = (pix_c >= 0 && c >= pix_c - 1 && c <= pix_c + 1);
            if (c == wr_c) begin
                address = 6'h38; data_read_n = 2'b10;
                #1 snap_before = data_out;
                data_read_n = 2'b11;
                address = 6'h30; data_in = 32'h1; data_write_n = 2'b00;
            end
        end
    endtask

    // 20-line frame, vsync on lines 0-1; one pixel at line pl, clock pc
    task automatic frame(input int pl, input int pc);
        for (int l = 0; l < 20; l++)
            vline(64, l < 2, (l == pl) ? pc : -1, -1);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus_rd(6'h38, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_status got %h want %h", d, 32'd0); end
        checks++;
        if (user_interrupt !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", user_interrupt); end
        checks++;
        if (data_ready !== 1'b1) begin errors++; $display("FAIL data_ready got %b want 1", data_ready); end
        checks++;
        if (uo_out !== 8'd0) begin errors++; $display("FAIL uo_out got %h want 00", uo_out); end
        bus_rd(6'h32, d); checks++;
        if (d !== 32'd56) begin errors++; $display("FAIL reset_xdiv got %0d want 56", d); end
        bus_rd(6'h34, d); checks++;
        if (d !== 32'd47) begin errors++; $display("FAIL reset_ydiv got %0d want 47", d); end
        bus_rd(6'h31, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_hstart got %0d want 0", d); end
        bus_rd(6'h33, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_vstart got %0d want 0", d); end
        bus_rd(6'h3C, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL reset_hperiod got %0d want 0", d); end
    endtask

    task automatic test_config;
        logic [31:0] d;
        bus_wr(6'h31, 32'd4);
        bus_wr(6'h32, 32'd1);
        bus_wr(6'h33, 32'd2);
        bus_wr(6'h34, 32'hFFFF_FF00);
        bus_rd(6'h31, d); checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL cfg_hstart got %0d want 4", d); end
        bus_rd(6'h32, d); checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL cfg_xdiv got %0d want 1", d); end
        bus_rd(6'h33, d); checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL cfg_vstart got %0d want 2", d); end
        bus_rd(6'h34, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL cfg_ydiv got %0d want 0", d); end
        bus_rd(6'h30, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL ctrl_read got %0d want 0", d); end
        bus_rd(6'h2C, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL unmapped got %h want 0", d); end
    endtask

    task automatic check_words(input string tag, input int wexp, input logic [31:0] vexp);
        logic [31:0] d, e;
        for (int w = 0; w < 10; w++) begin
            bus_rd(6'(w * 4), d);
            e = (w == wexp) ? vexp : 32'd0;
            checks++;
            if (d !== e) begin errors++; $display("FAIL %s word%0d got %h want %h", tag, w, d, e); end
        end
    endtask

    task automatic test_full_capture;
        logic [31:0] d;
        bus_wr(6'h30, 32'h1);
        bus_rd(6'h38, d); checks++;
        if (d !== 32'd2) begin errors++; $display("FAIL arm_status got %h want 2", d); end
        // row 3 sits on line 7; col 5 samples 22 clocks into the line
        frame(7, 22);
        bus_rd(6'h38, d); checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL full_status got %h want 1", d); end
        checks++;
        if (user_interrupt !== 1'b1) begin errors++; $display("FAIL full_irq got %b want 1", user_interrupt); end
        check_words("full", 2, 32'h0000_0002);
    endtask

    task automatic test_irq_clear;
        logic [31:0] d;
        bus_wr(6'h30, 32'h0);
        checks++;
        if (user_interrupt !== 1'b0) begin errors++; $display("FAIL irqclr_irq got %b want 0", user_interrupt); end
        bus_rd(6'h38, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL irqclr_status got %h want 0", d); end
    endtask

    task automatic test_abort;
        logic [31:0] d;
        bus_wr(6'h30, 32'h1);
        for (int l = 0; l < 9; l++) vline(64, l < 2, -1, -1);
        bus_rd(6'h38, d); checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL abort_mid got %h want 4", d); end
        vline(64, 1'b1, -1, -1);
        vline(64, 1'b0, -1, -1);
        bus_rd(6'h38, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL abort_status got %h want 0", d); end
        checks++;
        if (user_interrupt !== 1'b0) begin errors++; $display("FAIL abort_irq got %b want 0", user_interrupt); end
    endtask

    task automatic test_rearm;
        logic [31:0] d;
        bus_wr(6'h30, 32'h1);
        for (int l = 0; l < 6; l++) vline(64, l < 2, -1, -1);
        vline(64, 1'b0, -1, 30);
        checks++;
        if (snap_before !== 32'd6) begin errors++; $display("FAIL rearm_before got %h want 6", snap_before); end
        checks++;
        if (snap_after !== 32'd2) begin errors++; $display("FAIL rearm_after got %h want 2", snap_after); end
        // row 0 on line 4, col 19 samples 50 clocks into the line
        frame(4, 50);
        bus_rd(6'h38, d); checks++;
        if (d !== 32'd1) begin errors++; $display("FAIL rearm_status got %h want 1", d); end
        checks++;
        if (user_interrupt !== 1'b1) begin errors++; $display("FAIL rearm_irq got %b want 1", user_interrupt); end
        check_words("rearm", 0, 32'h0008_0000);
    endtask

    task automatic test_measure;
        logic [31:0] d;
`ifdef VGA_CAP_MEASURE_EN
        repeat (3) vline(1344, 1'b0, -1, -1);
        bus_rd(6'h3C, d); checks++;
        if (d !== 32'd1023) begin errors++; $display("FAIL hperiod_sat got %0d want 1023", d); end
        repeat (2) vline(800, 1'b0, -1, -1);
        bus_rd(6'h3C, d); checks++;
        if (d !== 32'd800) begin errors++; $display("FAIL hperiod_800 got %0d want 800", d); end
        for (int f = 0; f < 2; f++)
            for (int l = 0; l < 806; l++) vline(16, l < 2, -1, -1);
        for (int l = 0; l < 3; l++) vline(16, l < 2, -1, -1);
        bus_rd(6'h3D, d); checks++;
        if (d !== 32'd806) begin errors++; $display("FAIL vlines got %0d want 806", d); end
`else
        repeat (3) vline(800, 1'b0, -1, -1);
        bus_rd(6'h3C, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL hperiod_off got %0d want 0", d); end
        bus_rd(6'h3D, d); checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL vlines_off got %0d want 0", d); end
`endif
    endtask

    initial begin
        test_reset;
        test_config;
        test_full_capture;
        test_irq_clear;
        test_abort;
        test_rearm;
        test_measure;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
